// File: rtl/ibex_mem_responder_pkg.sv
// Shared types and helpers for the Ibex memory responder.
package ibex_mem_responder_pkg;

  typedef struct packed {
    logic        valid;
    logic        err;
    logic [31:0] rdata;
  } mem_rsp_t;

  localparam int unsigned MaxRspLatency       = 4;
  localparam int unsigned MaxOutstandingLimit = 4;
  localparam int unsigned OutCntWidth         = 3;

  // Wrap-around subtraction makes addresses below the base land far out of range.
  function automatic logic addr_in_range(input logic [31:0] addr,
                                         input logic [31:0] base,
                                         input logic [31:0] words);
    logic [31:0] idx;
    idx = (addr - base) >> 2;
    return idx < words;
  endfunction

endpackage

// File: rtl/ibex_mem_rsp_pipe.sv
// Fixed-depth delay line of responses, cleared by the synchronous active-low reset.
module ibex_mem_rsp_pipe
  import ibex_mem_responder_pkg::*;
#(
  parameter int unsigned Depth = 1
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  input  mem_rsp_t in_rsp,
  output mem_rsp_t out_rsp
);

  if (Depth == 0) begin : g_pass
    logic unused_ok;
    assign unused_ok = clk_i ^ rst_ni;
    assign out_rsp   = in_rsp;
  end else begin : g_stages
    mem_rsp_t stage_reg [Depth];

    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        for (int s = 0; s < int'(Depth); s++) stage_reg[s] <= '0;
      end else begin
        stage_reg[0] <= in_rsp;
        for (int s = 1; s < int'(Depth); s++) stage_reg[s] <= stage_reg[s-1];
      end
    end

    assign out_rsp = stage_reg[Depth-1];
  end

endmodule

// File: rtl/ibex_mem_responder.sv
// Memory-side responder for the Ibex req/gnt/rvalid bus, backed by a word-addressed RAM.
module ibex_mem_responder
  import ibex_mem_responder_pkg::*;
#(
  parameter int unsigned MemWords       = 1024,
  parameter logic [31:0] BaseAddr       = 32'h0010_0000,
  parameter int unsigned RspLatency     = 1,
  parameter int unsigned MaxOutstanding = 2,
  parameter int unsigned GntStallEvery  = 0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  output logic        gnt_o,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o
);

  localparam int unsigned AddrW  = $clog2(MemWords);
  localparam int unsigned StallW = $clog2(GntStallEvery) + 1;
  localparam logic [StallW-1:0] StallLast =
      (GntStallEvery == 0) ? '0 : StallW'(GntStallEvery - 1);
  localparam logic [OutCntWidth-1:0] MaxOut = OutCntWidth'(MaxOutstanding);

  if (GntStallEvery == 1) begin : g_bad_stall
    $error("GntStallEvery=1 would never grant");
  end
  if (RspLatency < 1 || RspLatency > MaxRspLatency) begin : g_bad_latency
    $error("RspLatency must be 1..%0d", MaxRspLatency);
  end
  if (MaxOutstanding < 1 || MaxOutstanding > MaxOutstandingLimit) begin : g_bad_outstanding
    $error("MaxOutstanding must be 1..%0d", MaxOutstandingLimit);
  end

  logic [31:0]            mem [MemWords];
  logic [AddrW-1:0]       idx;
  logic                   in_range;
  logic                   stall_now;
  logic [StallW-1:0]      stall_cnt_reg;
  logic [OutCntWidth-1:0] out_cnt_reg;
  logic                   valid0_reg;
  logic                   err0_reg;
  logic                   read0_reg;
  logic [31:0]            ram_q;
  mem_rsp_t               head_rsp;
  mem_rsp_t               tail_rsp;

  assign idx       = AddrW'((addr_i - BaseAddr) >> 2);
  assign in_range  = addr_in_range(addr_i, BaseAddr, MemWords);
  assign stall_now = (GntStallEvery != 0) && (stall_cnt_reg == StallLast);
  assign gnt_o     = rst_ni & req_i & (out_cnt_reg < MaxOut) & ~stall_now;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      stall_cnt_reg <= '0;
    end else if (req_i) begin
      stall_cnt_reg <= stall_now ? '0 : stall_cnt_reg + StallW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      out_cnt_reg <= '0;
    end else begin
      case ({gnt_o, rvalid_o})
        2'b10:   out_cnt_reg <= out_cnt_reg + OutCntWidth'(1);
        2'b01:   out_cnt_reg <= out_cnt_reg - OutCntWidth'(1);
        default: out_cnt_reg <= out_cnt_reg;
      endcase
    end
  end

  // RAM and its read register carry no reset so the array maps onto block RAM.
  always_ff @(posedge clk_i) begin
    if (gnt_o && in_range) begin
      if (we_i) begin
        for (int b = 0; b < 4; b++) begin
          if (be_i[b]) mem[idx][b*8 +: 8] <= wdata_i[b*8 +: 8];
        end
      end else begin
        ram_q <= mem[idx];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid0_reg <= 1'b0;
      err0_reg   <= 1'b0;
      read0_reg  <= 1'b0;
    end else begin
      valid0_reg <= gnt_o;
      err0_reg   <= gnt_o & ~in_range;
      read0_reg  <= gnt_o & in_range & ~we_i;
    end
  end

  // The first latency cycle is the RAM read register; the pipe adds the rest.
  always_comb begin
    head_rsp       = '0;
    head_rsp.valid = valid0_reg;
    head_rsp.err   = err0_reg;
    head_rsp.rdata = read0_reg ? ram_q : 32'h0;
  end

  ibex_mem_rsp_pipe #(
    .Depth(RspLatency - 1)
  ) u_rsp_pipe (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .in_rsp (head_rsp),
    .out_rsp(tail_rsp)
  );

  assign rvalid_o = tail_rsp.valid;
  assign err_o    = tail_rsp.err;
  assign rdata_o  = tail_rsp.rdata;

endmodule

// File: tb/tb_ibex_mem_responder.sv
// Self-checking bench: three responder configurations against a queue-based reference model.
module tb_ibex_mem_responder;

  localparam int NI = 3;
  localparam logic [31:0] BASE = 32'h0010_0000;
  localparam int MEMW = 1024;
  localparam int WIN  = 16;

  localparam int LAT_P [NI] = '{1, 3, 4};
  localparam int MO_P  [NI] = '{2, 2, 4};
  localparam int SE_P  [NI] = '{0, 0, 3};

  logic        clk;
  logic        rst_n  [NI];
  logic        req    [NI];
  logic        we     [NI];
  logic [3:0]  be     [NI];
  logic [31:0] addr   [NI];
  logic [31:0] wdata  [NI];
  logic        gnt    [NI];
  logic        rvalid [NI];
  logic        err    [NI];
  logic [31:0] rdata  [NI];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  ibex_mem_responder #(.RspLatency(1), .MaxOutstanding(2), .GntStallEvery(0)) dut0 (
    .clk_i(clk), .rst_ni(rst_n[0]), .req_i(req[0]), .gnt_o(gnt[0]), .we_i(we[0]),
    .be_i(be[0]), .addr_i(addr[0]), .wdata_i(wdata[0]), .rvalid_o(rvalid[0]),
    .rdata_o(rdata[0]), .err_o(err[0]));

  ibex_mem_responder #(.RspLatency(3), .MaxOutstanding(2), .GntStallEvery(0)) dut1 (
    .clk_i(clk), .rst_ni(rst_n[1]), .req_i(req[1]), .gnt_o(gnt[1]), .we_i(we[1]),
    .be_i(be[1]), .addr_i(addr[1]), .wdata_i(wdata[1]), .rvalid_o(rvalid[1]),
    .rdata_o(rdata[1]), .err_o(err[1]));

  ibex_mem_responder #(.RspLatency(4), .MaxOutstanding(4), .GntStallEvery(3)) dut2 (
    .clk_i(clk), .rst_ni(rst_n[2]), .req_i(req[2]), .gnt_o(gnt[2]), .we_i(we[2]),
    .be_i(be[2]), .addr_i(addr[2]), .wdata_i(wdata[2]), .rvalid_o(rvalid[2]),
    .rdata_o(rdata[2]), .err_o(err[2]));

  typedef struct {
    int          due;
    logic        err;
    logic [31:0] data;
  } exp_t;

  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  exp_t        pend [NI][$];
  exp_t        obs0 [$];
  logic [31:0] mem_m [NI][WIN];
  int          reqcnt [NI];
  int          gnt_tot [NI];
  int          rv_tot [NI];
  logic        gnt_seen [NI];
  int          cyc;
  int          checks;
  int          errors;
  logic        rec0;

  task automatic chk(input int inst, input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst=%0d cyc=%0d got=%h want=%h", name, inst, cyc, act, exp);
    end
  endtask

  task automatic set_idle();
    for (int i = 0; i < NI; i++) begin
      req[i] = 1'b0; we[i] = 1'b0; be[i] = 4'h0; addr[i] = 32'h0; wdata[i] = 32'h0;
    end
  endtask

  // One clock: compare outputs against the model mid-cycle, then advance the model.
  task automatic tick();
    #3;
    for (int i = 0; i < NI; i++) begin
      logic        eg;
      logic        ev;
      logic        stall;
      logic [31:0] idx;
      exp_t        e;
      stall = (SE_P[i] != 0) ? (((reqcnt[i] + 1) % SE_P[i]) == 0) : 1'b0;
      eg = rst_n[i] && req[i] && (pend[i].size() < MO_P[i]) && !stall;
      ev = (pend[i].size() > 0) && (pend[i][0].due == cyc);
      chk(i, "gnt", gnt[i], eg);
      chk(i, "rvalid", rvalid[i], ev);
      chk(i, "err", err[i], ev ? pend[i][0].err : 1'b0);
      chk(i, "rdata", rdata[i], ev ? pend[i][0].data : 32'h0);
      gnt_seen[i] = gnt[i];
      if (gnt[i]) gnt_tot[i]++;
      if (rvalid[i]) begin
        rv_tot[i]++;
        $display("rsp inst=%0d cyc=%0d err=%0b rdata=%h", i, cyc, err[i], rdata[i]);
        if (i == 0 && rec0) obs0.push_back('{cyc, err[i], rdata[i]});
      end
      if (ev) void'(pend[i].pop_front());
      if (!rst_n[i]) begin
        pend[i].delete();
        reqcnt[i] = 0;
      end else begin
        if (req[i]) reqcnt[i]++;
        if (eg) begin
          idx = (addr[i] - BASE) >> 2;
          e.due = cyc + LAT_P[i];
          e.err = 1'b0;
          e.data = 32'h0;
          if (idx >= MEMW) begin
            e.err = 1'b1;
          end else if (we[i]) begin
            if (idx < WIN)
              for (int b = 0; b < 4; b++)
                if (be[i][b]) mem_m[i][idx][b*8 +: 8] = wdata[i][b*8 +: 8];
          end else begin
            e.data = (idx < WIN) ? mem_m[i][idx] : 32'h0;
          end
          pend[i].push_back(e);
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic [31:0] rand_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r < 8) return BASE + 32'(4 * $urandom_range(0, WIN - 1)) + 32'($urandom_range(0, 3));
    if (r == 8) return BASE + 32'(4 * MEMW) + 32'(4 * $urandom_range(0, 7));
    return BASE - 32'(4 * (1 + $urandom_range(0, 7)));
  endfunction

  localparam int NV = 10;
  vec_t vec [NV];

  initial begin
    logic [9:0] pat10;
    logic [8:0] pat9;
    int k [NI];
    int ng, g0, r0, ksum;

    vec[0] = '{1'b1, 4'hF,    32'h0010_0004, 32'hDEAD_BEEF, 1'b0, 32'h0};
    vec[1] = '{1'b0, 4'hF,    32'h0010_0004, 32'h0,         1'b0, 32'hDEAD_BEEF};
    vec[2] = '{1'b1, 4'hF,    32'h0010_0008, 32'h1122_3344, 1'b0, 32'h0};
    vec[3] = '{1'b1, 4'b0010, 32'h0010_0008, 32'h0000_AB00, 1'b0, 32'h0};
    vec[4] = '{1'b0, 4'hF,    32'h0010_0008, 32'h0,         1'b0, 32'h1122_AB44};
    vec[5] = '{1'b0, 4'hF,    32'h0010_1000, 32'h0,         1'b1, 32'h0};
    vec[6] = '{1'b0, 4'hF,    32'h000F_FFFC, 32'h0,         1'b1, 32'h0};
    vec[7] = '{1'b0, 4'hF,    32'h0010_0004, 32'h0,         1'b0, 32'hDEAD_BEEF};
    vec[8] = '{1'b1, 4'h0,    32'h0010_0004, 32'hFFFF_FFFF, 1'b0, 32'h0};
    vec[9] = '{1'b0, 4'hF,    32'h0010_0006, 32'h0,         1'b0, 32'hDEAD_BEEF};

    checks = 0; errors = 0; cyc = 0; rec0 = 1'b0;
    for (int i = 0; i < NI; i++) begin
      rst_n[i] = 1'b0; reqcnt[i] = 0; gnt_tot[i] = 0; rv_tot[i] = 0; gnt_seen[i] = 1'b0; k[i] = 0;
      for (int w = 0; w < WIN; w++) mem_m[i][w] = 32'h0;
    end
    set_idle();
    @(posedge clk);
    #1;
    req[0] = 1'b1; req[1] = 1'b1; req[2] = 1'b1;
    tick();
    tick();
    set_idle();
    for (int i = 0; i < NI; i++) rst_n[i] = 1'b1;

    // Back-to-back table on the latency-1 instance.
    rec0 = 1'b1;
    g0 = cyc;
    for (int j = 0; j < NV; j++) begin
      req[0] = 1'b1; we[0] = vec[j].we; be[0] = vec[j].be;
      addr[0] = vec[j].addr; wdata[0] = vec[j].wdata;
      tick();
    end
    set_idle();
    tick(); tick();
    rec0 = 1'b0;
    chk(0, "tbl_count", obs0.size(), NV);
    for (int j = 0; j < NV && j < obs0.size(); j++) begin
      chk(0, "tbl_err", obs0[j].err, vec[j].exp_err);
      chk(0, "tbl_rdata", obs0[j].data, vec[j].exp_rdata);
      chk(0, "tbl_latency", obs0[j].due, g0 + j + 1);
    end

    // Fill the test window on every instance, holding each request until granted.
    for (int c = 0; c < 300; c++) begin
      if (k[0] >= WIN && k[1] >= WIN && k[2] >= WIN) break;
      for (int i = 0; i < NI; i++) begin
        req[i] = (k[i] < WIN); we[i] = 1'b1; be[i] = 4'hF;
        addr[i] = BASE + 32'(4 * k[i]); wdata[i] = $urandom;
      end
      tick();
      for (int i = 0; i < NI; i++) if (req[i] && gnt_seen[i]) k[i]++;
    end
    ksum = k[0] + k[1] + k[2];
    chk(0, "prefill_done", ksum, 3 * WIN);
    set_idle();
    for (int c = 0; c < 6; c++) tick();

    // Latency 3 with two outstanding: grants throttled by the outstanding limit.
    pat10 = '0; ng = 0; r0 = rv_tot[1];
    for (int c = 0; c < 10; c++) begin
      req[1] = 1'b1; we[1] = 1'b0; addr[1] = BASE + 32'(4 * ng);
      tick();
      pat10 = {pat10[8:0], gnt_seen[1]};
      if (gnt_seen[1]) ng++;
    end
    chk(1, "lat3_gnt_pattern", pat10, 10'b1100110011);
    set_idle();
    for (int c = 0; c < 8; c++) tick();
    chk(1, "lat3_rvalid_count", rv_tot[1] - r0, 6);

    // Stall every third request cycle.
    rst_n[2] = 1'b0; tick(); rst_n[2] = 1'b1;
    pat9 = '0; g0 = gnt_tot[2]; r0 = rv_tot[2];
    for (int c = 0; c < 9; c++) begin
      req[2] = 1'b1; we[2] = 1'b0; addr[2] = BASE + 32'(4 * c);
      tick();
      pat9 = {pat9[7:0], gnt_seen[2]};
    end
    chk(2, "stall_gnt_pattern", pat9, 9'b110110110);
    set_idle();
    for (int c = 0; c < 8; c++) tick();
    chk(2, "stall_gnt_count", gnt_tot[2] - g0, 6);
    chk(2, "stall_rvalid_count", rv_tot[2] - r0, 6);

    // Reset with two reads in flight: both dropped, grants resume at once.
    for (int c = 0; c < 2; c++) begin
      req[2] = 1'b1; we[2] = 1'b0; addr[2] = BASE + 32'h4;
      tick();
      chk(2, "inflight_gnt", gnt_seen[2], 1'b1);
    end
    set_idle();
    tick();
    rst_n[2] = 1'b0; tick(); rst_n[2] = 1'b1;
    r0 = rv_tot[2];
    req[2] = 1'b1; we[2] = 1'b0; addr[2] = BASE + 32'h8;
    tick();
    chk(2, "post_reset_gnt", gnt_seen[2], 1'b1);
    set_idle();
    for (int c = 0; c < 3; c++) tick();
    chk(2, "no_stale_rvalid", rv_tot[2] - r0, 0);
    tick();
    chk(2, "post_reset_rvalid", rv_tot[2] - r0, 1);

    // Randomised traffic with occasional resets on all instances.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NI; i++) begin
        rst_n[i] = ($urandom_range(0, 99) != 0);
        req[i]   = ($urandom_range(0, 3) != 0);
        we[i]    = 1'($urandom_range(0, 1));
        be[i]    = 4'($urandom);
        addr[i]  = rand_addr();
        wdata[i] = $urandom;
      end
      tick();
    end
    for (int i = 0; i < NI; i++) rst_n[i] = 1'b1;
    set_idle();
    for (int c = 0; c < 8; c++) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
